// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Default geometry lives here; instances override width/depth through parameters.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] raddr_t;

    // Write port roles: ALU result and load return.
    localparam int WR_ALU  = 0;
    localparam int WR_LOAD = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback.
// Lookups see this cycle's clears so a consumer can wake up on the same edge.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_READ*ADDR_W-1:0] lookup_addr_i,
    output logic [NUM_READ-1:0]        lookup_busy_o,
    input  logic [1:0]                 clr_en_i,
    input  logic [2*ADDR_W-1:0]        clr_addr_i,
    input  logic                       mark_en_i,
    input  logic [ADDR_W-1:0]          mark_addr_i
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Mark is applied after the clears so a newer producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < 2; k++) begin
            if (clr_en_i[k]) begin
                busy_d[clr_addr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (mark_en_i) begin
            busy_d[mark_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_lookup
        logic [ADDR_W-1:0] addr;
        logic              clr_hit;

        assign addr = lookup_addr_i[i*ADDR_W +: ADDR_W];

        always_comb begin
            clr_hit = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (clr_en_i[k] && clr_addr_i[k*ADDR_W +: ADDR_W] == addr) begin
                    clr_hit = 1'b1;
                end
            end
            // Writes are discarded during reset, so they cannot wake anything up.
            lookup_busy_o[i] = busy_q[addr] & ~(clr_hit & ~reset);
            if (ZERO_REG != 0 && addr == '0) begin
                lookup_busy_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Register file with NUM_READ combinational read ports, ALU and load write ports,
// optional write->read bypass, optional hardwired-zero R0 and a busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_READ*ADDR_W-1:0] readAddr,
    output logic [NUM_READ*DATA_W-1:0] readData,
    output logic [NUM_READ-1:0]        readBusy,
    input  logic [1:0]                 wrEn,
    input  logic [2*ADDR_W-1:0]        wrAddr,
    input  logic [2*DATA_W-1:0]        wrData,
    input  logic [1:0]                 wrClear,
    input  logic                       markEn,
    input  logic [ADDR_W-1:0]          markAddr
);

    typedef logic [DATA_W-1:0] data_t;

    data_t             mem_q [DEPTH];
    logic [DEPTH-1:0]  we_alu;
    logic [DEPTH-1:0]  we_load;
    logic [ADDR_W-1:0] wr_addr_alu;
    logic [ADDR_W-1:0] wr_addr_load;
    data_t             wr_data_alu;
    data_t             wr_data_load;

    assign wr_addr_alu  = wrAddr[WR_ALU*ADDR_W +: ADDR_W];
    assign wr_addr_load = wrAddr[WR_LOAD*ADDR_W +: ADDR_W];
    assign wr_data_alu  = wrData[WR_ALU*DATA_W +: DATA_W];
    assign wr_data_load = wrData[WR_LOAD*DATA_W +: DATA_W];

    always_comb begin
        we_alu                = '0;
        we_load               = '0;
        we_alu[wr_addr_alu]   = wrEn[WR_ALU];
        we_load[wr_addr_load] = wrEn[WR_LOAD];
        if (ZERO_REG != 0) begin
            we_alu[0]  = 1'b0;
            we_load[0] = 1'b0;
        end
    end

    // Load port takes priority when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (we_load[e]) begin
                    mem_q[e] <= wr_data_load;
                end else if (we_alu[e]) begin
                    mem_q[e] <= wr_data_alu;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_W-1:0] addr;
        data_t             rd;

        assign addr = readAddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem_q[addr];
            if (BYPASS != 0 && !reset) begin
                if (wrEn[WR_ALU] && wr_addr_alu == addr) begin
                    rd = wr_data_alu;
                end
                if (wrEn[WR_LOAD] && wr_addr_load == addr) begin
                    rd = wr_data_load;
                end
            end
            if (ZERO_REG != 0 && addr == '0) begin
                rd = '0;
            end
        end

        assign readData[i*DATA_W +: DATA_W] = rd;
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .lookup_addr_i (readAddr),
        .lookup_busy_o (readBusy),
        .clr_en_i      (wrEn & wrClear),
        .clr_addr_i    (wrAddr),
        .mark_en_i     (markEn),
        .mark_addr_i   (markAddr)
    );

endmodule
